reset_sequencer: RTL

- Runs on the divided core clock produced by the clock-divider stage.
- Generates the processor core's synchronous reset from the board-level reset and a raw pushbutton.
- Holds the core in reset for a fixed number of divided-clock cycles after any reset source clears, then flags readiness.
- Synchronizes and debounces the pushbutton; a debounced press forces a full reset/hold sequence.

---
 rtl/reset_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Core reset sequencer: board reset plus debounced pushbutton drive a registered core reset and ready flag.
// Optional build macro RESET_SEQ_COUNT_EN adds an 8-bit saturating count of button-triggered resets.
module reset_sequencer #(
   parameter int unsigned HOLD_CYCLES     = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inButton,
   output logic       outRst,
   output logic       outReady
`ifdef RESET_SEQ_COUNT_EN
   ,
   output logic [7:0] outRstCount
`endif
);

   localparam int          SYNC_STAGES = 2;
   localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] DEB_LAST    = 32'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      HOLD         = 2'd0,
      RUN          = 2'd1,
      DEBOUNCE     = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] hold_cnt_reg, hold_cnt_next;
   logic [31:0] deb_cnt_reg, deb_cnt_next;
   logic        out_rst_reg, out_rst_next;
   logic        out_ready_reg, out_ready_next;
   logic        sync_reg [SYNC_STAGES];
   logic        btn_s;

   // Metastability chain for the asynchronous button; each stage is cleared by rst.
   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         logic sync_d;
         if (gi == 0) begin : g_first
            assign sync_d = inButton;
         end else begin : g_chain
            assign sync_d = sync_reg[gi-1];
         end
         always_ff @(posedge clk) begin
            if (rst) sync_reg[gi] <= 1'b0;
            else     sync_reg[gi] <= sync_d;
         end
      end
   endgenerate

   assign btn_s = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= HOLD;
         hold_cnt_reg  <= '0;
         deb_cnt_reg   <= '0;
         out_rst_reg   <= 1'b1;
         out_ready_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         hold_cnt_reg  <= hold_cnt_next;
         deb_cnt_reg   <= deb_cnt_next;
         out_rst_reg   <= out_rst_next;
         out_ready_reg <= out_ready_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      hold_cnt_next  = hold_cnt_reg;
      deb_cnt_next   = deb_cnt_reg;
      out_rst_next   = out_rst_reg;
      out_ready_next = out_ready_reg;
      case (state_reg)
         HOLD: begin
            out_rst_next   = 1'b1;
            out_ready_next = 1'b0;
            if (hold_cnt_reg == HOLD_LAST) begin
               state_next   = RUN;
               out_rst_next = 1'b0;
            end else begin
               hold_cnt_next = hold_cnt_reg + 32'd1;
            end
         end
         RUN: begin
            // Ready trails the reset release by one edge so the core sees a clean cycle first.
            out_rst_next   = 1'b0;
            out_ready_next = 1'b1;
            deb_cnt_next   = '0;
            if (btn_s) state_next = DEBOUNCE;
         end
         DEBOUNCE: begin
            if (!btn_s) begin
               state_next   = RUN;
               deb_cnt_next = '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
               state_next     = WAIT_RELEASE;
               deb_cnt_next   = '0;
               out_rst_next   = 1'b1;
               out_ready_next = 1'b0;
            end else begin
               deb_cnt_next = deb_cnt_reg + 32'd1;
            end
         end
         WAIT_RELEASE: begin
            out_rst_next   = 1'b1;
            out_ready_next = 1'b0;
            if (!btn_s) begin
               state_next    = HOLD;
               hold_cnt_next = '0;
            end
         end
      endcase
   end

   assign outRst   = out_rst_reg;
   assign outReady = out_ready_reg;

`ifdef RESET_SEQ_COUNT_EN
   logic       press_accept;
   logic [7:0] rst_count_reg;

   assign press_accept = (state_reg == DEBOUNCE) && btn_s && (deb_cnt_reg == DEB_LAST);

   // Survives button resets; only the board reset clears it.
   always_ff @(posedge clk) begin
      if (rst)
         rst_count_reg <= 8'd0;
      else if (press_accept && (rst_count_reg != 8'hFF))
         rst_count_reg <= rst_count_reg + 8'd1;
   end

   assign outRstCount = rst_count_reg;
`endif

endmodule
